// File: rtl/ibex_pkg.sv
// Shared types and helpers for the multi-port register file and its wipe sequencer.
package ibex_pkg;

   // States of the register-file wipe sequencer
   typedef enum logic [1:0] {
      RF_WIPE_IDLE = 2'd0,
      RF_WIPE_WIPE = 2'd1,
      RF_WIPE_DONE = 2'd2
   } rf_wipe_state_e;

   // Number of architectural registers: RV32E has 16, RV32I has 32
   function automatic int unsigned rf_num_words(input bit rv32e);
      return rv32e ? 32'd16 : 32'd32;
   endfunction

endpackage

// File: rtl/ibex_rf_wipe_ctrl.sv
// Wipe sequencer: walks every nonzero register address once, then pulses done.
module ibex_rf_wipe_ctrl
   import ibex_pkg::*;
#(
   parameter int unsigned NumWords  = 32,
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wipe_req_i,
   output logic                 wipe_en_o,
   output logic                 wipe_first_o,
   output logic [AddrWidth-1:0] wipe_addr_o,
   output logic                 wipe_busy_o,
   output logic                 wipe_done_o
);

   localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);
   localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);

   rf_wipe_state_e       state_q;
   logic [AddrWidth-1:0] cnt_q;
   logic                 busy_q;
   logic                 done_q;

   // State, address counter and the registered busy/done flags move together
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RF_WIPE_IDLE;
         cnt_q   <= FirstAddr;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RF_WIPE_IDLE: begin
               if (wipe_req_i) begin
                  state_q <= RF_WIPE_WIPE;
                  cnt_q   <= FirstAddr;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RF_WIPE_WIPE: begin
               if (cnt_q == LastAddr) begin
                  state_q <= RF_WIPE_DONE;
                  cnt_q   <= FirstAddr;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + FirstAddr;
               end
            end
            RF_WIPE_DONE: begin
               state_q <= RF_WIPE_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= RF_WIPE_IDLE;
               cnt_q   <= FirstAddr;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wipe_en_o    = (state_q == RF_WIPE_WIPE);
   assign wipe_first_o = wipe_en_o && (cnt_q == FirstAddr);
   assign wipe_addr_o  = cnt_q;
   assign wipe_busy_o  = busy_q;
   assign wipe_done_o  = done_q;

endmodule

// File: rtl/prim_buf.sv
// Plain buffer primitive; keeps the decoded write-enable vector as a distinct net.
module prim_buf #(
   parameter int unsigned Width = 1
) (
   input  logic [Width-1:0] in_i,
   output logic [Width-1:0] out_o
);

   assign out_o = in_i;

endmodule

// File: rtl/prim_onehot_check.sv
// Checks a one-hot write-enable vector against its enable and source address.
module prim_onehot_check #(
   parameter int unsigned AddrWidth   = 5,
   parameter int unsigned OneHotWidth = 32
) (
   input  logic [OneHotWidth-1:0] oh_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic                   en_i,
   output logic                   err_o
);

   logic [OneHotWidth-1:0] oh_expected;
   logic                   oh_single;

   // Reference decode of the address, used to spot a vector that points at the wrong word
   always_comb begin
      oh_expected         = '0;
      oh_expected[addr_i] = 1'b1;
   end

   assign oh_single = (oh_i != '0) && ((oh_i & (oh_i - OneHotWidth'(1))) == '0);

   // Enabled: exactly one bit, at the addressed word. Disabled: no bits at all.
   assign err_o = en_i ? (!oh_single || (oh_i != oh_expected)) : (oh_i != '0);

endmodule

// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file with parameterised read/write ports, optional forwarding,
// dummy-instruction x0, write-enable glitch checking and a sequential wipe.
module ibex_register_file_mp
   import ibex_pkg::*;
#(
   parameter bit                      RV32E             = 1'b0,
   parameter int unsigned             DataWidth         = 32,
   parameter int unsigned             NumReadPorts      = 2,
   parameter int unsigned             NumWritePorts     = 1,
   parameter bit                      WriteForward      = 1'b0,
   parameter bit                      DummyInstructions = 1'b0,
   parameter bit                      WrenCheck         = 1'b0,
   parameter logic [DataWidth-1:0]    WordZeroVal       = '0
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    dummy_instr_id_i,
   input  logic                                    dummy_instr_wb_i,
   input  logic [NumReadPorts-1:0][4:0]            raddr_i,
   output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o,
   input  logic [NumWritePorts-1:0][4:0]           waddr_i,
   input  logic [NumWritePorts-1:0][DataWidth-1:0] wdata_i,
   input  logic [NumWritePorts-1:0]                we_i,
   input  logic                                    wipe_req_i,
   output logic                                    wipe_busy_o,
   output logic                                    wipe_done_o,
   output logic                                    err_o
);

   localparam int unsigned NUM_WORDS = rf_num_words(RV32E);
   localparam int unsigned ADDR_W    = $clog2(NUM_WORDS);

   logic [DataWidth-1:0]                 mem [NUM_WORDS];
   logic [DataWidth-1:0]                 mem_r0;
   logic [NumWritePorts-1:0][ADDR_W-1:0] waddr;
   logic [NumWritePorts-1:0]             wren_err;

   logic              wipe_en;
   logic              wipe_first;
   logic [ADDR_W-1:0] wipe_addr;
   logic              wipe_busy;
   logic              wipe_done;

   ibex_rf_wipe_ctrl #(
      .NumWords  (NUM_WORDS),
      .AddrWidth (ADDR_W)
   ) u_wipe_ctrl (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wipe_req_i   (wipe_req_i),
      .wipe_en_o    (wipe_en),
      .wipe_first_o (wipe_first),
      .wipe_addr_o  (wipe_addr),
      .wipe_busy_o  (wipe_busy),
      .wipe_done_o  (wipe_done)
   );

   for (genvar w = 0; w < NumWritePorts; w++) begin : g_wport
      assign waddr[w] = waddr_i[w][ADDR_W-1:0];

      if (WrenCheck) begin : g_chk
         logic [NUM_WORDS-1:0] wren_oh;
         logic [NUM_WORDS-1:0] wren_oh_buf;

         assign wren_oh = we_i[w] ? (NUM_WORDS'(1) << waddr[w]) : '0;

         prim_buf #(
            .Width (NUM_WORDS)
         ) u_wren_buf (
            .in_i  (wren_oh),
            .out_o (wren_oh_buf)
         );

         prim_onehot_check #(
            .AddrWidth   (ADDR_W),
            .OneHotWidth (NUM_WORDS)
         ) u_wren_chk (
            .oh_i   (wren_oh_buf),
            .addr_i (waddr[w]),
            .en_i   (we_i[w]),
            .err_o  (wren_err[w])
         );
      end else begin : g_nochk
         assign wren_err[w] = 1'b0;
      end
   end

   // Storage: wipe has priority, normal writes only when idle; higher port wins a collision
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem[i] <= WordZeroVal;
         end
         mem_r0 <= WordZeroVal;
      end else if (wipe_en) begin
         mem[wipe_addr] <= WordZeroVal;
         if (wipe_first) begin
            mem_r0 <= WordZeroVal;
         end
      end else if (!wipe_busy) begin
         for (int w = 0; w < NumWritePorts; w++) begin
            if (we_i[w] && (waddr[w] != '0)) begin
               mem[waddr[w]] <= wdata_i[w];
            end
         end
         if (DummyInstructions && we_i[0] && dummy_instr_wb_i && (waddr[0] == '0)) begin
            mem_r0 <= wdata_i[0];
         end
      end
   end

   // Read mux: x0 is constant unless a dummy sees mem_r0; forwarding only while idle
   always_comb begin
      for (int p = 0; p < NumReadPorts; p++) begin
         rdata_o[p] = WordZeroVal;
         if (raddr_i[p][ADDR_W-1:0] == '0) begin
            if (DummyInstructions && dummy_instr_id_i) begin
               rdata_o[p] = mem_r0;
            end
         end else begin
            rdata_o[p] = mem[raddr_i[p][ADDR_W-1:0]];
            if (WriteForward && !wipe_busy) begin
               for (int w = 0; w < NumWritePorts; w++) begin
                  if (we_i[w] && (waddr[w] == raddr_i[p][ADDR_W-1:0])) begin
                     rdata_o[p] = wdata_i[w];
                  end
               end
            end
         end
      end
   end

   assign wipe_busy_o = wipe_busy;
   assign wipe_done_o = wipe_done;
   assign err_o       = (|wren_err) | (wipe_busy & (|we_i));

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Self-checking bench: a full-featured instance against an array model plus a
// minimal RV32E instance for addressing, no-forwarding and short-wipe behaviour.
module tb_ibex_register_file_mp;

   localparam int NRP = 3;
   localparam int NWP = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic                 dummy_id, dummy_wb;
   logic [NRP-1:0][4:0]  raddr;
   logic [NRP-1:0][31:0] rdata;
   logic [NWP-1:0][4:0]  waddr;
   logic [NWP-1:0][31:0] wdata;
   logic [NWP-1:0]       we;
   logic                 wipe_req, busy, done, err;

   logic [1:0][4:0]      raddr_b;
   logic [1:0][31:0]     rdata_b;
   logic [0:0][4:0]      waddr_b;
   logic [0:0][31:0]     wdata_b;
   logic [0:0]           we_b;
   logic                 wipe_req_b, busy_b, done_b, err_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];
   logic [31:0] model_r0;

   ibex_register_file_mp #(
      .RV32E (1'b0), .DataWidth (32), .NumReadPorts (NRP), .NumWritePorts (NWP),
      .WriteForward (1'b1), .DummyInstructions (1'b1), .WrenCheck (1'b1), .WordZeroVal (32'h0)
   ) dut (
      .clk_i (clk), .rst_ni (rst_n), .dummy_instr_id_i (dummy_id), .dummy_instr_wb_i (dummy_wb),
      .raddr_i (raddr), .rdata_o (rdata), .waddr_i (waddr), .wdata_i (wdata), .we_i (we),
      .wipe_req_i (wipe_req), .wipe_busy_o (busy), .wipe_done_o (done), .err_o (err)
   );

   ibex_register_file_mp #(
      .RV32E (1'b1)
   ) dut_b (
      .clk_i (clk), .rst_ni (rst_n), .dummy_instr_id_i (dummy_id), .dummy_instr_wb_i (dummy_wb),
      .raddr_i (raddr_b), .rdata_o (rdata_b), .waddr_i (waddr_b), .wdata_i (wdata_b), .we_i (we_b),
      .wipe_req_i (wipe_req_b), .wipe_busy_o (busy_b), .wipe_done_o (done_b), .err_o (err_b)
   );

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic check_bit(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic idle_inputs();
      we = '0; waddr = '0; wdata = '0; raddr = '0;
      dummy_id = 1'b0; dummy_wb = 1'b0; wipe_req = 1'b0;
      we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0; wipe_req_b = 1'b0;
   endtask

   // Architectural view of a read: x0 rule, then newest same-cycle write, then stored value
   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic dummy_sel);
      if (a == 5'd0) return dummy_sel ? model_r0 : 32'h0;
      for (int w = NWP - 1; w >= 0; w--) begin
         if (we[w] && waddr[w] == a) return wdata[w];
      end
      return model[a];
   endfunction

   // Apply this cycle's writes to the model in port order, so port 1 overrides port 0
   task automatic commit_model();
      for (int w = 0; w < NWP; w++) begin
         if (we[w] && waddr[w] != 5'd0) model[waddr[w]] = wdata[w];
      end
      if (we[0] && waddr[0] == 5'd0 && dummy_wb) model_r0 = wdata[0];
   endtask

   task automatic apply_stimulus();
      commit_model();
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_r0 = 32'h0;
   endtask

   task automatic sweep_read(input string tag);
      for (int a = 0; a < 32; a++) begin
         idle_inputs();
         dummy_id = 1'b1;
         raddr[a % NRP] = 5'(a);
         #1;
         check_output($sformatf("%s_x%0d", tag, a), rdata[a % NRP], exp_read(5'(a), 1'b1));
         @(negedge clk);
      end
   endtask

   task automatic random_cycle();
      for (int w = 0; w < NWP; w++) begin
         we[w]    = 1'($urandom_range(0, 1));
         waddr[w] = 5'($urandom_range(0, 31));
         wdata[w] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) waddr[1] = waddr[0];
      for (int p = 0; p < NRP; p++) raddr[p] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) raddr[0] = waddr[1];
      if ($urandom_range(0, 2) == 0) raddr[1] = waddr[0];
      if ($urandom_range(0, 7) == 0) raddr[2] = 5'd0;
      dummy_id = 1'($urandom_range(0, 1));
      dummy_wb = 1'($urandom_range(0, 1));
      #1;
      for (int p = 0; p < NRP; p++) begin
         check_output($sformatf("rand_rd%0d_x%0d", p, raddr[p]), rdata[p], exp_read(raddr[p], dummy_id));
      end
      check_bit("rand_err", err, 1'b0);
      apply_stimulus();
   endtask

   int busy_cycles, done_cnt, done_at;

   initial begin
      idle_inputs();
      clear_model();
      #12;
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check_bit("rst_busy_b", busy_b, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep_read("post_reset");

      // x5 write then read on every port; x0 write is discarded
      we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
      apply_stimulus();
      idle_inputs();
      for (int p = 0; p < NRP; p++) raddr[p] = 5'd5;
      #1;
      for (int p = 0; p < NRP; p++) check_output($sformatf("x5_port%0d", p), rdata[p], 32'hDEADBEEF);
      we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h1;
      apply_stimulus();
      idle_inputs();
      #1 check_output("x0_plain", rdata[0], 32'h0);
      dummy_id = 1'b1;
      #1 check_output("x0_dummy_after_plain_write", rdata[0], 32'h0);
      @(negedge clk);

      // Both write ports hit x7: port 1 wins
      idle_inputs();
      we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 32'h11; wdata[1] = 32'h22;
      apply_stimulus();
      idle_inputs();
      raddr[1] = 5'd7;
      #1 check_output("x7_collision", rdata[1], 32'h22);
      @(negedge clk);

      // Same-cycle forwarding of x3
      idle_inputs();
      we[1] = 1'b1; waddr[1] = 5'd3; wdata[1] = 32'hA5A5A5A5; raddr[2] = 5'd3; raddr[0] = 5'd3;
      #1;
      check_output("fwd_x3_port2", rdata[2], 32'hA5A5A5A5);
      check_output("fwd_x3_port0", rdata[0], 32'hA5A5A5A5);
      apply_stimulus();
      idle_inputs();
      raddr[2] = 5'd3;
      #1 check_output("x3_stored", rdata[2], 32'hA5A5A5A5);
      @(negedge clk);

      // Dummy write to x0 only visible to a dummy in ID
      idle_inputs();
      we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h55; dummy_wb = 1'b1;
      apply_stimulus();
      idle_inputs();
      dummy_id = 1'b1;
      #1 check_output("x0_dummy_id", rdata[0], 32'h55);
      dummy_id = 1'b0;
      #1 check_output("x0_nondummy", rdata[0], 32'h0);
      @(negedge clk);

      idle_inputs();
      repeat (300) random_cycle();

      // Two-hot decode on write port 0, with and without the enable
      idle_inputs();
      force dut.g_wport[0].g_chk.wren_oh_buf = 32'h0000_0030;
      #1 check_bit("wren_twohot_we0", err, 1'b1);
      we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'h4444;
      #1 check_bit("wren_twohot_we1", err, 1'b1);
      release dut.g_wport[0].g_chk.wren_oh_buf;
      #1 check_bit("wren_released", err, 1'b0);
      apply_stimulus();

      // Fill every register and the dummy x0, then wipe
      idle_inputs();
      for (int i = 1; i < 32; i++) begin
         we[0] = 1'b1; waddr[0] = 5'(i); wdata[0] = $urandom | 32'h1;
         apply_stimulus();
      end
      we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hCAFE; dummy_wb = 1'b1;
      apply_stimulus();
      idle_inputs();
      wipe_req = 1'b1;
      apply_stimulus();
      wipe_req = 1'b0;
      busy_cycles = 0; done_cnt = 0; done_at = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy) break;
         busy_cycles++;
         if (done) begin
            done_cnt++;
            done_at = busy_cycles;
         end
         we = '0;
         if (busy_cycles == 3) begin
            we[0] = 1'b1; waddr[0] = 5'd31; wdata[0] = 32'hBAD; raddr[0] = 5'd31; raddr[1] = 5'd1;
            #1;
            check_bit("wipe_we_err_mid", err, 1'b1);
            check_output("wipe_read_unwiped_x31", rdata[0], model[31]);
            check_output("wipe_read_wiped_x1", rdata[1], 32'h0);
         end else if (done) begin
            we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h1234;
            #1 check_bit("wipe_we_err_done", err, 1'b1);
         end
         @(negedge clk);
      end
      idle_inputs();
      check_output("wipe_busy_cycles", 32'(busy_cycles), 32'd32);
      check_output("wipe_done_count", 32'(done_cnt), 32'd1);
      check_output("wipe_done_last", 32'(done_at), 32'd32);
      clear_model();
      sweep_read("post_wipe");

      // Reset in the middle of a wipe aborts it with no done pulse
      idle_inputs();
      we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'h77;
      apply_stimulus();
      idle_inputs();
      wipe_req = 1'b1;
      apply_stimulus();
      wipe_req = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      raddr[0] = 5'd4;
      #1;
      check_bit("midwipe_rst_busy", busy, 1'b0);
      check_bit("midwipe_rst_done", done, 1'b0);
      check_output("midwipe_rst_x4", rdata[0], 32'h0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      busy_cycles = 0; done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) done_cnt++;
      end
      check_output("after_rst_busy_cycles", 32'(busy_cycles), 32'd0);
      check_output("after_rst_done_pulses", 32'(done_cnt), 32'd0);
      we[0] = 1'b1; waddr[0] = 5'd6; wdata[0] = 32'h600D;
      apply_stimulus();
      idle_inputs();
      raddr[0] = 5'd6;
      #1 check_output("after_rst_write_x6", rdata[0], 32'h600D);
      @(negedge clk);

      // RV32E instance: low address bits only, no forwarding, plain x0
      idle_inputs();
      we_b[0] = 1'b1; waddr_b[0] = 5'd21; wdata_b[0] = 32'hDEADBEEF; raddr_b[0] = 5'd5;
      #1 check_output("e_no_forward", rdata_b[0], 32'h0);
      @(negedge clk);
      idle_inputs();
      raddr_b[0] = 5'd5; raddr_b[1] = 5'd21;
      #1;
      check_output("e_x5_alias_lo", rdata_b[0], 32'hDEADBEEF);
      check_output("e_x5_alias_hi", rdata_b[1], 32'hDEADBEEF);
      we_b[0] = 1'b1; waddr_b[0] = 5'd0; wdata_b[0] = 32'h55; dummy_wb = 1'b1;
      @(negedge clk);
      idle_inputs();
      dummy_id = 1'b1;
      #1 check_output("e_x0_no_dummy_regs", rdata_b[0], 32'h0);
      wipe_req_b = 1'b1;
      @(negedge clk);
      wipe_req_b = 1'b0;
      busy_cycles = 0; done_cnt = 0; done_at = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy_b) break;
         busy_cycles++;
         if (done_b) begin
            done_cnt++;
            done_at = busy_cycles;
         end
         we_b = '0;
         if (busy_cycles == 1) begin
            we_b[0] = 1'b1; waddr_b[0] = 5'd6; wdata_b[0] = 32'h99;
            #1 check_bit("e_wipe_we_err", err_b, 1'b1);
         end
         @(negedge clk);
      end
      idle_inputs();
      check_output("e_wipe_busy_cycles", 32'(busy_cycles), 32'd16);
      check_output("e_wipe_done_count", 32'(done_cnt), 32'd1);
      check_output("e_wipe_done_last", 32'(done_at), 32'd16);
      raddr_b[0] = 5'd5; raddr_b[1] = 5'd6;
      #1;
      check_output("e_post_wipe_x5", rdata_b[0], 32'h0);
      check_output("e_post_wipe_x6", rdata_b[1], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
